// File: rtl/serial_mag_cmp_if.sv
// rtl/serial_mag_cmp_if.sv - request/result bundle for the bit-serial magnitude comparator
//
// Purpose: groups the start handshake, operand inputs and registered
// result outputs of serial_mag_cmp into one bundle.
// Signals:
//   start       request pulse (master -> slave)
//   signed_mode 0 = unsigned, 1 = two's-complement (master -> slave)
//   in1, in2    WIDTH-bit operands A and B (master -> slave)
//   busy        compare in progress (slave -> master)
//   done        one-cycle result-valid pulse (slave -> master)
//   gt, eq, lt  A > B, A == B, A < B (slave -> master)
//   cycles      RUN cycles used by the last compare (slave -> master)
interface serial_mag_cmp_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [CW-1:0]    cycles;

  modport master (
    output start, signed_mode, in1, in2,
    input  busy, done, gt, eq, lt, cycles
  );

  modport slave (
    input  start, signed_mode, in1, in2,
    output busy, done, gt, eq, lt, cycles
  );
endinterface

// File: rtl/serial_mag_cmp.sv
// rtl/serial_mag_cmp.sv - bit-serial MSB-first magnitude comparator with early exit
//
// Purpose: compares two WIDTH-bit operands one bit per cycle starting at
// the MSB, stopping at the first differing bit, in unsigned or
// two's-complement mode. All outputs are registered.
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset
//   bus  serial_mag_cmp_if slave: start/signed_mode/in1/in2 in,
//        busy/done/gt/eq/lt/cycles out
module serial_mag_cmp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_mag_cmp_if.slave    bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             mode_q, mode_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic [CW-1:0]    cycles_q, cycles_d;

  logic             a_bit;
  logic             b_bit;
  logic             at_msb;
  logic             finish;

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    cycles_d = cycles_q;
    finish   = 1'b0;

    a_bit  = op_a_q[idx_q];
    b_bit  = op_b_q[idx_q];
    at_msb = (idx_q == IW'(WIDTH - 1));

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_a_d   = bus.in1;
          op_b_d   = bus.in2;
          mode_d   = bus.signed_mode;
          idx_d    = IW'(WIDTH - 1);
          gt_d     = 1'b0;
          eq_d     = 1'b0;
          lt_d     = 1'b0;
          cycles_d = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        cycles_d = cycles_q + CW'(1);
        if (a_bit != b_bit) begin
          // A differing sign bit means the operand with the 1 is negative,
          // so the sense of the comparison is inverted at the MSB only.
          if (at_msb && mode_q) begin
            gt_d = b_bit;
            lt_d = a_bit;
          end else begin
            gt_d = a_bit;
            lt_d = b_bit;
          end
          finish = 1'b1;
        end else if (idx_q == '0) begin
          eq_d   = 1'b1;
          finish = 1'b1;
        end else begin
          idx_d = idx_q - IW'(1);
        end

        if (finish) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      mode_q   <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      cycles_q <= cycles_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.gt     = gt_q;
  assign bus.eq     = eq_q;
  assign bus.lt     = lt_q;
  assign bus.cycles = cycles_q;
endmodule

// File: tb/tb_serial_mag_cmp.sv
// tb/tb_serial_mag_cmp.sv - self-checking bench for serial_mag_cmp (WIDTH=8 and WIDTH=2)
module tb_serial_mag_cmp;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  serial_mag_cmp_if #(.WIDTH(8)) bus8 ();
  serial_mag_cmp_if #(.WIDTH(2)) bus2 ();

  serial_mag_cmp #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_mag_cmp #(.WIDTH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input int w, input bit s, input logic [31:0] a, input logic [31:0] b, input bit m);
    if (w == 8) begin
      bus8.start       = s;
      bus8.in1         = a[7:0];
      bus8.in2         = b[7:0];
      bus8.signed_mode = m;
    end else begin
      bus2.start       = s;
      bus2.in1         = a[1:0];
      bus2.in2         = b[1:0];
      bus2.signed_mode = m;
    end
  endtask

  // 0 busy, 1 done, 2 gt, 3 eq, 4 lt, 5 cycles
  function automatic logic [31:0] obs(input int w, input int which);
    logic [31:0] r;
    r = '0;
    if (w == 8) begin
      case (which)
        0: r = 32'(bus8.busy);
        1: r = 32'(bus8.done);
        2: r = 32'(bus8.gt);
        3: r = 32'(bus8.eq);
        4: r = 32'(bus8.lt);
        default: r = 32'(bus8.cycles);
      endcase
    end else begin
      case (which)
        0: r = 32'(bus2.busy);
        1: r = 32'(bus2.done);
        2: r = 32'(bus2.gt);
        3: r = 32'(bus2.eq);
        4: r = 32'(bus2.lt);
        default: r = 32'(bus2.cycles);
      endcase
    end
    return r;
  endfunction

  // Reference: numeric comparison of the operands as integers, and the
  // cycle count from the position of the highest differing bit.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input bit m,
                       output bit egt, output bit eeq, output bit elt, output int k);
    longint av, bv, x;
    int     p;
    av = longint'(a) & ((64'sd1 <<< w) - 1);
    bv = longint'(b) & ((64'sd1 <<< w) - 1);
    x  = av ^ bv;
    if (m && av[w-1]) av = av - (64'sd1 <<< w);
    if (m && bv[w-1]) bv = bv - (64'sd1 <<< w);
    egt = (av > bv);
    eeq = (av == bv);
    elt = (av < bv);
    p = -1;
    for (int i = 0; i < w; i++) if (x[i]) p = i;
    k = (p < 0) ? w : (w - p);
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic start_cmp(input int w, input logic [31:0] a, input logic [31:0] b, input bit m);
    drive(w, 1'b1, a, b, m);
    @(negedge clk);
    drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
    chk("busy_after_start", obs(w, 0), 1);
    chk("done_after_start", obs(w, 1), 0);
    chk("flags_cleared", obs(w, 2) | obs(w, 3) | obs(w, 4), 0);
    chk("cycles_cleared", obs(w, 5), 0);
  endtask

  // Returns at the falling edge where done is high (or after timeout).
  task automatic finish_cmp(input int w, input logic [31:0] a, input logic [31:0] b, input bit m, input int n0);
    bit egt, eeq, elt;
    int k, n;
    model(w, a, b, m, egt, eeq, elt, k);
    n = n0;
    while (obs(w, 1) == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", obs(w, 1), 1);
    chk("latency", 32'(n), 32'(k));
    chk("busy_at_done", obs(w, 0), 0);
    chk("gt", obs(w, 2), 32'(egt));
    chk("eq", obs(w, 3), 32'(eeq));
    chk("lt", obs(w, 4), 32'(elt));
    chk("cycles", obs(w, 5), 32'(k));
    chk("onehot", obs(w, 2) + obs(w, 3) + obs(w, 4), 1);
  endtask

  task automatic pulse_end(input int w);
    @(negedge clk);
    chk("done_one_cycle", obs(w, 1), 0);
  endtask

  task automatic run_cmp(input int w, input logic [31:0] a, input logic [31:0] b, input bit m);
    start_cmp(w, a, b, m);
    finish_cmp(w, a, b, m, 0);
    pulse_end(w);
  endtask

  initial begin
    bit          seen_done;
    logic [31:0] ra, rb;
    bit          rm;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    drive(8, 1'b0, 0, 0, 1'b0);
    drive(2, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_busy", obs(8, 0), 0);
    chk("rst_done", obs(8, 1), 0);
    chk("rst_flags", obs(8, 2) | obs(8, 3) | obs(8, 4), 0);
    chk("rst_cycles", obs(8, 5), 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset during RUN aborts without a done pulse.
    start_cmp(8, 32'h00, 32'h01, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_run_cycles", obs(8, 5), 3);
    chk("mid_run_busy", obs(8, 0), 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", obs(8, 0), 0);
    chk("abort_done", obs(8, 1), 0);
    chk("abort_flags", obs(8, 2) | obs(8, 3) | obs(8, 4), 0);
    chk("abort_cycles", obs(8, 5), 0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (obs(8, 1) != 0 || obs(8, 0) != 0) seen_done = 1'b1;
    end
    chk("no_done_after_abort", 32'(seen_done), 0);

    // Directed boundary cases.
    run_cmp(8, 32'h80, 32'h7F, 1'b0);
    run_cmp(8, 32'h80, 32'h7F, 1'b1);
    run_cmp(8, 32'hA5, 32'hA5, 1'b0);
    run_cmp(8, 32'hFF, 32'hFE, 1'b1);
    run_cmp(8, 32'h7F, 32'h80, 1'b1);

    // Second start during RUN is ignored.
    start_cmp(8, 32'h01, 32'h02, 1'b0);
    @(negedge clk);
    drive(8, 1'b1, 32'hFF, 32'h00, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 32'h00, 32'h00, 1'b0);
    finish_cmp(8, 32'h01, 32'h02, 1'b0, 2);
    pulse_end(8);

    // Back-to-back: start in the done cycle.
    start_cmp(8, 32'h3C, 32'h3D, 1'b0);
    finish_cmp(8, 32'h3C, 32'h3D, 1'b0, 0);
    start_cmp(8, 32'h10, 32'h10, 1'b0);
    finish_cmp(8, 32'h10, 32'h10, 1'b0, 0);
    pulse_end(8);

    // Randomised compares, biased toward every possible exit position.
    for (int it = 0; it < 60; it++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (32'h1 << $urandom_range(0, 7));
        default: rb = $urandom;
      endcase
      rm = 1'($urandom);
      start_cmp(8, ra, rb, rm);
      finish_cmp(8, ra, rb, rm, 0);
      if ($urandom_range(0, 1) == 1) pulse_end(8);
    end
    pulse_end(8);

    // Exhaustive sweep on the 2-bit instance.
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          run_cmp(2, 32'(a), 32'(b), 1'(m));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_mag_cmp.md
# serial_mag_cmp

Parametrised, sequential successor to the team's 2-bit combinational magnitude comparator (three outputs: greater/equal/less). It compares two WIDTH-bit operands bit-serially, MSB first, under a start/done handshake. It supports unsigned and two's-complement modes and terminates early at the first differing bit. It sits on the lab datapath wherever operand widths make a flat comparator impractical, and it reports how many cycles each compare took.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1), width of the cycle-count output (derived; not overridden).

- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- signed_mode  input  1  0 = unsigned compare, 1 = two's-complement; captured with start.
- in1  input  WIDTH  operand A; captured with start.
- in2  input  WIDTH  operand B; captured with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse: result valid.
- gt  output  1  A > B.
- eq  output  1  A == B.
- lt  output  1  A < B.
- cycles  output  CW  number of RUN cycles used by the last compare.

## Operation
- FSM with two states: IDLE and RUN. Internal registers: opA and opB (WIDTH bits), mode, and idx (bit index).
- IDLE:
  - On start=1, capture in1, in2 and signed_mode.
  - Set idx=WIDTH-1, clear gt/eq/lt/cycles to 0, go to RUN.
- RUN, each cycle, examines bit idx of opA and opB and increments cycles:
  - Bits differ and idx<WIDTH-1, or idx==WIDTH-1 with mode=0: gt=opA[idx], lt=opB[idx].
  - Bits differ, idx==WIDTH-1, mode=1: the sign bits decide, so gt=opB[idx] and lt=opA[idx].
  - Bits equal and idx==0: eq=1.
  - Any of the three cases above ends the compare: done=1 for that one cycle, then go to IDLE.
  - Otherwise decrement idx and stay in RUN.
- Exactly one of gt/eq/lt is 1 after a compare. All three hold their value until the next accepted start.
- start while busy=1 is ignored. Operand inputs are don't-care outside the accept cycle.
- Reset, asynchronous, may arrive at any time including mid-RUN: state=IDLE, busy=0, done=0, gt=eq=lt=0, cycles=0, idx=0. The aborted compare produces no done.

## Timing
- Edge E0 samples start in IDLE. busy goes high after E0.
- RUN edges E1..Ek follow, where k = WIDTH-p, p being the highest differing bit position; k = WIDTH if the operands are equal.
- The decision is registered on edge Ek:
  - done, gt/eq/lt and cycles=k become visible after Ek.
  - busy falls after Ek; done is high for exactly one cycle.
- Minimum latency is 1 RUN cycle (MSB differs). Maximum is WIDTH RUN cycles (equal operands, or only bit 0 differs).
- Back-to-back compares: start may be asserted in the cycle done is high (state is already IDLE). That start is accepted on the next edge; results clear to 0 at that edge.
- cycles never exceeds WIDTH; CW bits always suffice.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan (WIDTH=8)
- Reset mid-RUN: start with A=0x00, B=0x01, assert rst after 3 RUN cycles -> busy=0, gt=eq=lt=0, cycles=0 immediately, and no done pulse follows.
- Unsigned early exit: A=0x80, B=0x7F, signed_mode=0 -> done after 1 RUN cycle, gt=1, cycles=1. Same operands with signed_mode=1 -> lt=1, cycles=1.
- Equal operands: A=B=0xA5 -> done after 8 RUN cycles, eq=1, cycles=8. Signed A=0xFF (-1), B=0xFE (-2) -> gt=1, cycles=8.
- Busy rejection: start A=0x01, B=0x02, then pulse start with A=0xFF, B=0x00 during RUN -> result lt=1, cycles=7; the second request is never executed.
- Back-to-back: assert start with A=0x10, B=0x10 in the done cycle of the previous compare -> accepted on the next edge, flags clear, then eq=1 with cycles=8.
- Exhaustive sweep with WIDTH=2 (re-parametrised): all 16 in1/in2 pairs in both modes, checked against a reference model -> gt/eq/lt match and exactly one flag is set per compare.
